// File: rtl/dut_multi_fifo_logic_if.sv
// Addressed write/read method bus for dut_multi_fifo_logic.
// Carries the write method (write_address, write_data, write_en, write_rdy)
// and the read method (read_address, read_en, read_data, read_rdy).
// master: the caller driving methods; slave: the design serving them.
// DATA_W must match the DATA_W of the attached design.
interface dut_multi_fifo_logic_if #(
  parameter int unsigned DATA_W = 8
);
  logic [3:0]        write_address;
  logic [DATA_W-1:0] write_data;
  logic              write_en;
  logic              write_rdy;
  logic [3:0]        read_address;
  logic              read_en;
  logic [DATA_W-1:0] read_data;
  logic              read_rdy;

  modport master (
    output write_address, write_data, write_en, read_address, read_en,
    input  write_rdy, read_data, read_rdy
  );

  modport slave (
    input  write_address, write_data, write_en, read_address, read_en,
    output write_rdy, read_data, read_rdy
  );
endinterface

// File: rtl/dut_multi_fifo_logic.sv
// N_IN input FIFOs merged word-by-word into one output FIFO by a combiner
// whose operation (OR/AND/XOR/ADD) is selected at runtime through a mode
// register. All access goes through an addressed write/read method bus.
// Ports:
//   CLK   - single clock, rising edge
//   RST_N - synchronous reset, active high (1 = reset)
//   bus   - dut_multi_fifo_logic_if.slave method bus; read_data is
//           combinational from read_address, write_rdy/read_rdy registered
// Optional feature: define MFL_STATS_EN to add a 16-bit saturating count of
// combiner fires, readable (and clear-on-read) at read address 0x5.
module dut_multi_fifo_logic #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_IN   = 2,
  parameter int unsigned DEPTH  = 4
) (
  input logic                   CLK,
  input logic                   RST_N,
  dut_multi_fifo_logic_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Pointer increment that wraps modulo DEPTH (DEPTH need not be a power of 2).
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Register state
  logic [DATA_W-1:0] in_mem    [N_IN][DEPTH];
  logic [PTR_W-1:0]  in_rd_ptr [N_IN];
  logic [PTR_W-1:0]  in_wr_ptr [N_IN];
  logic [CNT_W-1:0]  in_cnt    [N_IN];
  logic [DATA_W-1:0] out_mem   [DEPTH];
  logic [PTR_W-1:0]  out_rd_ptr;
  logic [PTR_W-1:0]  out_wr_ptr;
  logic [CNT_W-1:0]  out_cnt;
  logic [1:0]        mode;
  logic              overflow;
  logic              underflow;
  logic              rdy;

  // Decoded method actions
  logic              wr_act;
  logic              rd_act;
  logic [N_IN-1:0]   in_push;
  logic [N_IN-1:0]   in_accept;
  logic              all_ready;
  logic              fire;
  logic              out_pop;
  logic              overflow_evt;
  logic              underflow_evt;
  logic              flag_clr;
  logic [DATA_W-1:0] combined;

  assign wr_act = bus.write_en & rdy;
  assign rd_act = bus.read_en & rdy;

  // Combiner fires only from start-of-cycle state: no bypass through a same-cycle pop.
  always_comb begin
    all_ready = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (in_cnt[i] == '0) all_ready = 1'b0;
    end
  end
  assign fire = all_ready & (out_cnt != CNT_FULL);

  // A push into a full input is still accepted when the combiner frees a slot this cycle.
  always_comb begin
    in_push   = '0;
    in_accept = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_push[i]   = wr_act & (bus.write_address == 4'(4 + i));
      in_accept[i] = in_push[i] & ((in_cnt[i] != CNT_FULL) | fire);
    end
  end

  assign overflow_evt  = |(in_push & ~in_accept);
  assign out_pop       = rd_act & (bus.read_address == 4'h3) & (out_cnt != '0);
  assign underflow_evt = rd_act & (bus.read_address == 4'h3) & (out_cnt == '0);
  assign flag_clr      = rd_act & (bus.read_address == 4'h4);

  // Reduce all input heads with the selected operation.
  always_comb begin
    combined = in_mem[0][in_rd_ptr[0]];
    for (int i = 1; i < N_IN; i++) begin
      case (mode)
        2'd0:    combined = combined | in_mem[i][in_rd_ptr[i]];
        2'd1:    combined = combined & in_mem[i][in_rd_ptr[i]];
        2'd2:    combined = combined ^ in_mem[i][in_rd_ptr[i]];
        default: combined = combined + in_mem[i][in_rd_ptr[i]];
      endcase
    end
  end

  // Method ready: low through reset, high from the first edge out of reset.
  always_ff @(posedge CLK) begin
    if (RST_N) rdy <= 1'b0;
    else       rdy <= 1'b1;
  end

  assign bus.write_rdy = rdy;
  assign bus.read_rdy  = rdy;

  // Mode register and sticky error flags; a same-cycle event beats a clear.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      mode      <= 2'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_act && bus.write_address == 4'h2) mode <= bus.write_data[1:0];
      overflow  <= (overflow  & ~flag_clr) | overflow_evt;
      underflow <= (underflow & ~flag_clr) | underflow_evt;
    end
  end

  // Input FIFO pointers and counts.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      for (int i = 0; i < N_IN; i++) begin
        in_rd_ptr[i] <= '0;
        in_wr_ptr[i] <= '0;
        in_cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (in_accept[i]) in_wr_ptr[i] <= ptr_next(in_wr_ptr[i]);
        if (fire)         in_rd_ptr[i] <= ptr_next(in_rd_ptr[i]);
        in_cnt[i] <= in_cnt[i] + CNT_W'(in_accept[i]) - CNT_W'(fire);
      end
    end
  end

  // Input FIFO storage.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_IN; i++) begin
      if (in_accept[i]) in_mem[i][in_wr_ptr[i]] <= bus.write_data;
    end
  end

  // Output FIFO pointers and count.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      out_rd_ptr <= '0;
      out_wr_ptr <= '0;
      out_cnt    <= '0;
    end else begin
      if (fire)    out_wr_ptr <= ptr_next(out_wr_ptr);
      if (out_pop) out_rd_ptr <= ptr_next(out_rd_ptr);
      out_cnt <= out_cnt + CNT_W'(fire) - CNT_W'(out_pop);
    end
  end

  // Output FIFO storage.
  always_ff @(posedge CLK) begin
    if (fire) out_mem[out_wr_ptr] <= combined;
  end

`ifdef MFL_STATS_EN
  logic [15:0] fire_cnt;
  logic        stats_clr;

  assign stats_clr = rd_act & (bus.read_address == 4'h5);

  // Saturating fire counter; a fire in the clearing cycle leaves it at 1.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      fire_cnt <= 16'd0;
    end else if (stats_clr) begin
      fire_cnt <= 16'(fire);
    end else if (fire && fire_cnt != 16'hFFFF) begin
      fire_cnt <= fire_cnt + 16'd1;
    end
  end
`endif

  // Combinational read mux, zero-extended.
  always_comb begin
    bus.read_data = '0;
    case (bus.read_address)
      4'h0: bus.read_data = DATA_W'(out_cnt != '0);
      4'h1: bus.read_data = DATA_W'(out_cnt);
      4'h2: bus.read_data = DATA_W'(mode);
      4'h3: if (out_cnt != '0) bus.read_data = out_mem[out_rd_ptr];
      4'h4: bus.read_data = DATA_W'({underflow, overflow});
`ifdef MFL_STATS_EN
      4'h5: bus.read_data = DATA_W'(fire_cnt);
`endif
      default: bus.read_data = '0;
    endcase
    for (int i = 0; i < N_IN; i++) begin
      if (bus.read_address == 4'(8 + i)) bus.read_data = DATA_W'(in_cnt[i] != CNT_FULL);
    end
  end
endmodule

// File: tb/tb_dut_multi_fifo_logic.sv
// Directed bench for dut_multi_fifo_logic at DATA_W=8, N_IN=2, DEPTH=4.
// Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
module tb_dut_multi_fifo_logic;
  localparam int unsigned DATA_W = 8;

  logic CLK;
  logic RST_N;
  int unsigned vectors;
  int unsigned miscompares;

  dut_multi_fifo_logic_if #(.DATA_W(DATA_W)) bus ();

  dut_multi_fifo_logic #(.DATA_W(DATA_W), .N_IN(2), .DEPTH(4)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data);
    bus.write_address = addr;
    bus.write_data    = data;
    bus.write_en      = 1'b1;
    step();
    bus.write_en      = 1'b0;
  endtask

  task automatic rd(input logic [3:0] addr, input logic [7:0] expv, input string tag);
    bus.read_address = addr;
    bus.read_en      = 1'b0;
    #1;
    check(tag, bus.read_data, expv);
  endtask

  task automatic rd_pop(input logic [3:0] addr, input logic [7:0] expv, input string tag);
    bus.read_address = addr;
    bus.read_en      = 1'b1;
    #1;
    check(tag, bus.read_data, expv);
    step();
    bus.read_en = 1'b0;
  endtask

  initial begin
    vectors           = 0;
    miscompares       = 0;
    RST_N             = 1'b1;
    bus.write_address = '0;
    bus.write_data    = '0;
    bus.write_en      = 1'b0;
    bus.read_address  = '0;
    bus.read_en       = 1'b0;

    // Reset for two cycles
    step();
    step();
    check("wr_rdy_in_reset", 8'(bus.write_rdy), 8'h00);
    check("rd_rdy_in_reset", 8'(bus.read_rdy), 8'h00);
    RST_N = 1'b0;
    step();
    check("wr_rdy_after_reset", 8'(bus.write_rdy), 8'h01);
    check("rd_rdy_after_reset", 8'(bus.read_rdy), 8'h01);
    rd(4'h0, 8'h00, "reset_not_empty");
    rd(4'h1, 8'h00, "reset_count");
    rd(4'h2, 8'h00, "reset_mode");
    rd(4'h8, 8'h01, "reset_in0_not_full");
    rd(4'h9, 8'h01, "reset_in1_not_full");
    rd(4'h7, 8'h00, "unmapped_read");

    // Default-mode (OR) combine and its latency
    wr(4'h4, 8'h0F);
    wr(4'h5, 8'hF0);
    rd(4'h0, 8'h00, "or_not_ready_1_edge");
    step();
    rd(4'h0, 8'h01, "or_not_empty");
    rd(4'h1, 8'h01, "or_count");
    rd_pop(4'h3, 8'hFF, "or_result");
    rd(4'h1, 8'h00, "or_count_after_pop");

    // Mode sweep: AND, XOR, ADD
    wr(4'h2, 8'h01);
    wr(4'h4, 8'hA5);
    wr(4'h5, 8'h3C);
    step();
    wr(4'h2, 8'h02);
    wr(4'h4, 8'hA5);
    wr(4'h5, 8'h3C);
    step();
    wr(4'h2, 8'h03);
    wr(4'h4, 8'hF0);
    wr(4'h5, 8'h20);
    step();
    rd(4'h2, 8'h03, "mode_readback");
    rd(4'h1, 8'h03, "sweep_count");
    rd_pop(4'h3, 8'h24, "and_result");
    rd_pop(4'h3, 8'h99, "xor_result");
    rd_pop(4'h3, 8'h10, "add_result");
    rd(4'h4, 8'h00, "flags_clean");

    // Backpressure and overflow on input 0
    wr(4'h4, 8'h01);
    wr(4'h4, 8'h02);
    wr(4'h4, 8'h03);
    rd(4'h8, 8'h01, "in0_not_full_at_3");
    wr(4'h4, 8'h04);
    rd(4'h8, 8'h00, "in0_full_at_4");
    rd(4'h9, 8'h01, "in1_not_full");
    wr(4'h4, 8'h05);
    wr(4'h4, 8'h06);
    rd_pop(4'h4, 8'h01, "overflow_flag");
    rd(4'h4, 8'h00, "overflow_cleared");

    // Fill the output with 4 OR results (x | 0) and queue a fifth pair
    wr(4'h2, 8'h00);
    wr(4'h5, 8'h00);
    wr(4'h5, 8'h00);
    wr(4'h5, 8'h00);
    wr(4'h5, 8'h00);
    step();
    rd(4'h1, 8'h04, "out_full_count");
    wr(4'h4, 8'h50);
    wr(4'h5, 8'h05);
    step();
    rd(4'h1, 8'h04, "out_count_holds");
    rd(4'h8, 8'h01, "in0_holding_one");
    rd_pop(4'h3, 8'h01, "drain_1");
    rd(4'h1, 8'h03, "count_after_pop");
    step();
    rd(4'h1, 8'h04, "fifth_pushed");
    rd_pop(4'h3, 8'h02, "drain_2");
    rd_pop(4'h3, 8'h03, "drain_3");
    rd_pop(4'h3, 8'h04, "drain_4");
    rd_pop(4'h3, 8'h55, "drain_5");
    rd(4'h0, 8'h00, "drained_empty");
    rd_pop(4'h3, 8'h00, "empty_pop_data");
    rd_pop(4'h4, 8'h02, "underflow_flag");
    rd(4'h4, 8'h00, "underflow_cleared");

    // Mid-operation reset with two results queued
    wr(4'h2, 8'h02);
    wr(4'h4, 8'h11);
    wr(4'h5, 8'h22);
    step();
    wr(4'h4, 8'h33);
    wr(4'h5, 8'h44);
    step();
    rd(4'h1, 8'h02, "queued_before_reset");
    RST_N = 1'b1;
    step();
    check("rdy_during_mid_reset", 8'(bus.read_rdy), 8'h00);
    RST_N = 1'b0;
    step();
    rd(4'h1, 8'h00, "count_after_mid_reset");
    rd(4'h2, 8'h00, "mode_after_mid_reset");
    rd(4'h0, 8'h00, "empty_after_mid_reset");
    rd(4'h5, 8'h00, "stats_after_reset");

    // Three combines after reset (OR of 0x01, 0x02)
    for (int k = 0; k < 3; k++) begin
      wr(4'h4, 8'h01);
      wr(4'h5, 8'h02);
      step();
    end
    rd(4'h1, 8'h03, "three_results");
`ifdef MFL_STATS_EN
    rd_pop(4'h5, 8'h03, "stats_three_fires");
    rd(4'h5, 8'h00, "stats_cleared");
`else
    rd_pop(4'h5, 8'h00, "stats_absent");
`endif
    rd_pop(4'h3, 8'h03, "post_reset_result");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
